// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: address width, architectural
// register count and the hard-wired zero register index.
package reg_scoreboard_pkg;
  localparam int                  REG_ADDR_W = 5;
  localparam int                  NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// Single saturating up/down pending-write counter with synchronous clear.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Next count: simultaneous inc and dec cancel; both ends saturate.
  always_comb begin
    w_count_nxt = r_count;
    case ({i_inc, i_dec})
      2'b10: begin
        if (r_count != CNT_MAX) w_count_nxt = r_count + CNT_ONE;
        else                    w_count_nxt = r_count;
      end
      2'b01: begin
        if (r_count != CNT_ZERO) w_count_nxt = r_count - CNT_ONE;
        else                     w_count_nxt = r_count;
      end
      default: w_count_nxt = r_count;
    endcase
  end

  // Counter state; reset outranks clear, clear outranks inc/dec.
  always_ff @(posedge clk) begin
    if (reset)      r_count <= CNT_ZERO;
    else if (i_clr) r_count <= CNT_ZERO;
    else            r_count <= w_count_nxt;
  end

  assign o_count = r_count;
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters, RAW/overflow
// stall generation, busy vector and sticky writeback-underflow flag.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int CNT_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [REG_ADDR_W-1:0] issue_dest_addr,
  input  logic [REG_ADDR_W-1:0] inst_read_reg_addr1,
  input  logic [REG_ADDR_W-1:0] inst_read_reg_addr2,
  input  logic                  src_use1,
  input  logic                  src_use2,
  input  logic                  reg_wr,
  input  logic [REG_ADDR_W-1:0] reg_wr_addr,
  input  logic                  flush,
  output logic                  stall_flag,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  err_underflow
);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    w_count [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc_vec;
  logic [NUM_REGS-1:0] w_dec_vec;
  logic                w_raw;
  logic                w_ovf;
  logic                w_accept;
  logic                w_underflow;
  logic                r_err_underflow;

  assign w_count[0] = CNT_ZERO;

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc_vec[g]),
        .i_dec   (w_dec_vec[g]),
        .i_clr   (flush),
        .o_count (w_count[g])
      );
    end
  endgenerate

  // Hazard detection against registered counts only (no writeback bypass).
  always_comb begin
    w_raw = 1'b0;
    w_ovf = 1'b0;
    if (src_use1 && (inst_read_reg_addr1 != ZERO_REG) &&
        (w_count[inst_read_reg_addr1] != CNT_ZERO)) w_raw = 1'b1;
    else w_raw = 1'b0;
    if (src_use2 && (inst_read_reg_addr2 != ZERO_REG) &&
        (w_count[inst_read_reg_addr2] != CNT_ZERO)) w_raw = 1'b1;
    else w_raw = w_raw;
    if (issue_wr && (issue_dest_addr != ZERO_REG) &&
        (w_count[issue_dest_addr] == CNT_MAX)) w_ovf = 1'b1;
    else w_ovf = 1'b0;
  end

  assign stall_flag = issue_valid & (w_raw | w_ovf);
  assign w_accept   = issue_valid & ~stall_flag & ~flush;

  // Per-register increment/decrement strobes; decrement only when pending.
  always_comb begin
    w_inc_vec = {NUM_REGS{1'b0}};
    w_dec_vec = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      w_inc_vec[i] = w_accept && issue_wr && (issue_dest_addr == REG_ADDR_W'(i));
      w_dec_vec[i] = reg_wr && (reg_wr_addr == REG_ADDR_W'(i)) &&
                     (w_count[i] != CNT_ZERO);
    end
  end

  // Busy bits derive from the registered counters.
  always_comb begin
    busy_vec = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = (w_count[i] != CNT_ZERO);
    end
  end

  assign w_underflow = reg_wr && (reg_wr_addr != ZERO_REG) &&
                       (w_count[reg_wr_addr] == CNT_ZERO);

  // Sticky underflow flag; a flush cycle neither sets nor clears it.
  always_ff @(posedge clk) begin
    if (reset)                     r_err_underflow <= 1'b0;
    else if (!flush && w_underflow) r_err_underflow <= 1'b1;
    else                           r_err_underflow <= r_err_underflow;
  end

  assign err_underflow = r_err_underflow;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_wr;
  logic [4:0]  issue_dest_addr, inst_read_reg_addr1, inst_read_reg_addr2;
  logic        src_use1, src_use2;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic        flush;
  logic        stall_flag;
  logic [31:0] busy_vec;
  logic        err_underflow;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk                 (clk),
    .reset               (reset),
    .issue_valid         (issue_valid),
    .issue_wr            (issue_wr),
    .issue_dest_addr     (issue_dest_addr),
    .inst_read_reg_addr1 (inst_read_reg_addr1),
    .inst_read_reg_addr2 (inst_read_reg_addr2),
    .src_use1            (src_use1),
    .src_use2            (src_use2),
    .reg_wr              (reg_wr),
    .reg_wr_addr         (reg_wr_addr),
    .flush               (flush),
    .stall_flag          (stall_flag),
    .busy_vec            (busy_vec),
    .err_underflow       (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0; issue_dest_addr = 5'd0;
    inst_read_reg_addr1 = 5'd0; inst_read_reg_addr2 = 5'd0;
    src_use1 = 1'b0; src_use2 = 1'b0; reg_wr = 1'b0; reg_wr_addr = 5'd0; flush = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] dest);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_dest_addr = dest;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_err", {31'd0, err_underflow}, 32'd0);
    chk("rst_stall", {31'd0, stall_flag}, 32'd0);

    // RAW on register 5 until the cycle after its writeback
    issue(5'd5); #1;
    chk("s1_first_nostall", {31'd0, stall_flag}, 32'd0);
    tick();
    chk("s1_busy5", busy_vec, 32'h0000_0020);
    issue_wr = 1'b0; inst_read_reg_addr1 = 5'd5; src_use1 = 1'b1; #1;
    chk("s1_raw_stall", {31'd0, stall_flag}, 32'd1);
    tick();
    chk("s1_raw_stall2", {31'd0, stall_flag}, 32'd1);
    reg_wr = 1'b1; reg_wr_addr = 5'd5; #1;
    chk("s1_no_bypass", {31'd0, stall_flag}, 32'd1);
    tick();
    reg_wr = 1'b0; #1;
    chk("s1_released", {31'd0, stall_flag}, 32'd0);
    chk("s1_busy_clear", busy_vec, 32'h0);
    src_use1 = 1'b0; issue_valid = 1'b0;
    tick();

    // Second source port and valid gating
    issue(5'd15); tick();
    issue_wr = 1'b0; inst_read_reg_addr2 = 5'd15; src_use2 = 1'b1; #1;
    chk("src2_stall", {31'd0, stall_flag}, 32'd1);
    src_use2 = 1'b0; #1;
    chk("src2_unused", {31'd0, stall_flag}, 32'd0);
    src_use2 = 1'b1; issue_valid = 1'b0; #1;
    chk("novalid_nostall", {31'd0, stall_flag}, 32'd0);
    idle(); reg_wr = 1'b1; reg_wr_addr = 5'd15; tick();
    idle(); #1;
    chk("src2_drain", busy_vec, 32'h0);

    // Overflow at count 3 on register 7
    for (int k = 0; k < 3; k++) begin
      issue(5'd7); #1;
      chk("s2_accept", {31'd0, stall_flag}, 32'd0);
      tick();
    end
    chk("s2_busy7", busy_vec, 32'h0000_0080);
    #1;
    chk("s2_ovf_stall", {31'd0, stall_flag}, 32'd1);
    tick();
    reg_wr = 1'b1; reg_wr_addr = 5'd7; #1;
    chk("s2_ovf_with_wb", {31'd0, stall_flag}, 32'd1);
    tick();
    reg_wr = 1'b0; #1;
    chk("s2_fourth_accept", {31'd0, stall_flag}, 32'd0);
    tick();
    idle(); #1;
    issue(5'd7); #1;
    chk("s2_full_again", {31'd0, stall_flag}, 32'd1);
    idle();
    for (int k = 0; k < 3; k++) begin
      reg_wr = 1'b1; reg_wr_addr = 5'd7; tick();
    end
    idle(); #1;
    chk("s2_drained", busy_vec, 32'h0);
    chk("s2_no_err", {31'd0, err_underflow}, 32'd0);

    // Same-cycle inc and dec on register 9
    issue(5'd9); tick();
    reg_wr = 1'b1; reg_wr_addr = 5'd9; #1;
    chk("s3_nostall", {31'd0, stall_flag}, 32'd0);
    tick();
    idle(); #1;
    chk("s3_busy9", busy_vec, 32'h0000_0200);
    reg_wr = 1'b1; reg_wr_addr = 5'd9; tick();
    idle(); #1;
    chk("s3_count_was_one", busy_vec, 32'h0);
    chk("s3_no_err", {31'd0, err_underflow}, 32'd0);

    // Underflow on register 12, sticky, cleared by reset
    reg_wr = 1'b1; reg_wr_addr = 5'd12; tick();
    idle(); #1;
    chk("s4_err_set", {31'd0, err_underflow}, 32'd1);
    chk("s4_busy_zero", busy_vec, 32'h0);
    tick();
    chk("s4_err_sticky", {31'd0, err_underflow}, 32'd1);
    reset = 1'b1; tick();
    reset = 1'b0; #1;
    chk("s4_err_reset", {31'd0, err_underflow}, 32'd0);
    reg_wr = 1'b1; reg_wr_addr = 5'd0; tick();
    idle(); #1;
    chk("s4_zero_wb_noerr", {31'd0, err_underflow}, 32'd0);

    // Register 0 never tracked or hazardous
    for (int k = 0; k < 5; k++) begin
      issue(5'd0); inst_read_reg_addr1 = 5'd0; src_use1 = 1'b1; #1;
      chk("s5_stall0", {31'd0, stall_flag}, 32'd0);
      tick();
      chk("s5_busy0", busy_vec, 32'h0);
    end
    idle();

    // Flush clears everything and suppresses a same-cycle issue
    issue(5'd3); tick();
    issue(5'd4); tick();
    idle(); #1;
    chk("s6_busy34", busy_vec, 32'h0000_0018);
    issue(5'd6); flush = 1'b1; #1;
    chk("s6_flush_nostall", {31'd0, stall_flag}, 32'd0);
    tick();
    idle(); #1;
    chk("s6_busy_flushed", busy_vec, 32'h0);
    reg_wr = 1'b1; reg_wr_addr = 5'd6; flush = 1'b1; tick();
    idle(); #1;
    chk("s6_flush_keeps_err", {31'd0, err_underflow}, 32'd0);
    reg_wr = 1'b1; reg_wr_addr = 5'd6; tick();
    idle(); #1;
    chk("s6_r6_was_zero", {31'd0, err_underflow}, 32'd1);
    reg_wr = 1'b1; reg_wr_addr = 5'd3; flush = 1'b1; tick();
    idle(); #1;
    chk("s6_flush_holds_err", {31'd0, err_underflow}, 32'd1);

    // Reset priority and mid-operation reset
    reset = 1'b1; tick();
    idle(); issue(5'd20); tick();
    idle(); #1;
    chk("rst_pre_busy20", busy_vec, 32'h0010_0000);
    reset = 1'b1; issue(5'd10); reg_wr = 1'b1; reg_wr_addr = 5'd20; tick();
    idle(); #1;
    chk("rst_prio_busy", busy_vec, 32'h0);
    chk("rst_prio_err", {31'd0, err_underflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
